// File: rtl/div.sv
// div: 32-bit signed/unsigned restoring radix-2 divider for the EX stage.
// Result is {remainder, quotient} written as {HI, LO}. A normal divide takes
// a fixed 34 edges from acceptance to ready_o; divide-by-zero takes 2 and
// returns 0 without trapping.
// Optional build macro DIV_EARLY_TERM_EN: when defined, a nonzero divisor
// whose magnitude exceeds the dividend's magnitude finishes in 1 edge.
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // Working register: [64:33] partial remainder, [31:0] quotient bits
    // shifted in from the bottom while dividend bits shift out of the top.
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        signed_q, signed_d;
    logic        neg1_q, neg1_d;
    logic        neg2_q, neg2_d;
    logic [63:0] res_q, res_d;
    logic        ready_q, ready_d;
    logic [63:0] result_q, result_d;

    logic [31:0] abs1, abs2;
    logic [32:0] trial;
    logic [31:0] quot_fix, rem_fix;
    logic        early_term;

    // Operand magnitudes; unsigned or non-negative operands pass through.
    assign abs1 = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    assign abs2 = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

    // 33-bit trial subtract; bit 32 set means the divisor did not fit.
    assign trial = {1'b0, work_q[63:32]} - {1'b0, divisor_q};

    // Sign correction applied once the 32 magnitude steps are done.
    assign quot_fix = (signed_q && (neg1_q ^ neg2_q)) ? (~work_q[31:0] + 32'd1) : work_q[31:0];
    assign rem_fix  = (signed_q && neg1_q) ? (~work_q[64:33] + 32'd1) : work_q[64:33];

`ifdef DIV_EARLY_TERM_EN
    assign early_term = (abs1 < abs2);
`else
    assign early_term = 1'b0;
`endif

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            divisor_q <= 32'd0;
            signed_q  <= 1'b0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            res_q     <= 64'd0;
            ready_q   <= 1'b0;
            result_q  <= 64'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            neg1_q    <= neg1_d;
            neg2_q    <= neg2_d;
            res_q     <= res_d;
            ready_q   <= ready_d;
            result_q  <= result_d;
        end
    end

    // Next-state and next-datapath logic; outputs are registered so ready_o
    // rises one edge after END is entered.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        neg1_d    = neg1_q;
        neg2_d    = neg2_q;
        res_d     = res_q;
        ready_d   = 1'b0;
        result_d  = 64'd0;

        case (state_q)
            FREE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == 32'd0) begin
                        state_d = BYZERO;
                    end else if (early_term) begin
                        // Quotient is zero and the dividend is the remainder.
                        res_d   = {opdata1_i, 32'd0};
                        state_d = END;
                    end else begin
                        divisor_d = abs2;
                        work_d    = {32'd0, abs1, 1'b0};
                        signed_d  = signed_div_i;
                        neg1_d    = opdata1_i[31];
                        neg2_d    = opdata2_i[31];
                        cnt_d     = 6'd0;
                        state_d   = ON;
                    end
                end
            end

            BYZERO: begin
                res_d   = 64'd0;
                state_d = END;
            end

            ON: begin
                if (annul_i) begin
                    // Flush: drop the partial result entirely.
                    work_d  = 65'd0;
                    cnt_d   = 6'd0;
                    state_d = FREE;
                end else if (cnt_q == 6'd32) begin
                    res_d   = {rem_fix, quot_fix};
                    cnt_d   = 6'd0;
                    state_d = END;
                end else begin
                    if (trial[32]) begin
                        work_d = {work_q[63:0], 1'b0};
                    end else begin
                        work_d = {trial[31:0], work_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end
            end

            END: begin
                if (start_i) begin
                    ready_d  = 1'b1;
                    result_d = res_q;
                end else begin
                    state_d = FREE;
                end
            end

            default: begin
                state_d = FREE;
            end
        endcase
    end

    assign ready_o  = ready_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_div.sv
// tb_div: directed vectors for div with hand-computed {HI, LO} results and
// fixed latencies. Build with DIV_EARLY_TERM_EN defined to match an RTL
// build that enables early termination.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef DIV_EARLY_TERM_EN
    localparam int ET_LAT = 1;
`else
    localparam int ET_LAT = 34;
`endif

    always #5 clk = ~clk;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One full transaction: accept, scramble operands, wait for ready_o,
    // poke annul_i while in END, then release start_i.
    task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp,
                          input int lat, input int annul_at);
        int n;
        n = 0;
        @(negedge clk);
        signed_div_i = sgn; opdata1_i = a; opdata2_i = b; start_i = 1'b1; annul_i = 1'b0;
        @(posedge clk); #1;
        signed_div_i = ~sgn; opdata1_i = ~a; opdata2_i = 32'd0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            annul_i = (i == annul_at);
            @(posedge clk); #1;
            n = i;
            if (ready_o) break;
        end
        $display("div %s sgn=%0d %h / %h -> %h after %0d edges", tag, sgn, a, b, result_o, n);
        check($sformatf("%s.lat", tag), 64'(n), 64'(lat));
        check($sformatf("%s.res", tag), result_o, exp);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk); #1;
        check($sformatf("%s.hold_rdy", tag), {63'd0, ready_o}, 64'd1);
        check($sformatf("%s.hold_res", tag), result_o, exp);
        @(negedge clk);
        annul_i = 1'b0; start_i = 1'b0;
        @(posedge clk); #1;
        check($sformatf("%s.drop_rdy", tag), {63'd0, ready_o}, 64'd0);
        check($sformatf("%s.drop_res", tag), result_o, 64'd0);
    endtask

    initial begin
        int seen;
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
        opdata1_i = 32'd0; opdata2_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.rdy", {63'd0, ready_o}, 64'd0);
        check("reset.res", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        do_div("u100_7",   1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 34, 0);
        do_div("s-7_2",    1'b1, 32'hFFFFFFF9, 32'h00000002, 64'hFFFFFFFF_FFFFFFFD, 34, 0);
        do_div("u_dz",     1'b0, 32'd12345,    32'd0,        64'h0,                 2,  1);
        do_div("s_dz",     1'b1, 32'hFFFFFFFB, 32'd0,        64'h0,                 2,  2);
        do_div("u5_9",     1'b0, 32'd5,        32'd9,        64'h00000005_00000000, ET_LAT, 0);
        do_div("s7_-2",    1'b1, 32'd7,        32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 34, 0);
        do_div("s-8_-3",   1'b1, 32'hFFFFFFF8, 32'hFFFFFFFD, 64'hFFFFFFFE_00000002, 34, 0);
        do_div("uF9_2",    1'b0, 32'hFFFFFFF9, 32'h00000002, 64'h00000001_7FFFFFFC, 34, 0);
        do_div("uFF_16",   1'b0, 32'hFFFFFFFF, 32'h00000010, 64'h0000000F_0FFFFFFF, 34, 0);
        do_div("s-3_7",    1'b1, 32'hFFFFFFFD, 32'd7,        64'hFFFFFFFD_00000000, ET_LAT, 0);
        do_div("s3_-7",    1'b1, 32'd3,        32'hFFFFFFF9, 64'h00000003_00000000, ET_LAT, 0);
        do_div("uFF_FF",   1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001, 34, 0);
        do_div("smin_1",   1'b1, 32'h80000000, 32'd1,        64'h00000000_80000000, 34, 0);

        // annul_i together with start_i in FREE must block acceptance.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1; annul_i = 1'b1;
        repeat (3) @(posedge clk);
        do_div("annfree",  1'b0, 32'd100,      32'd7,        64'h00000002_0000000E, 34, 0);

        // Annul mid-ON at E10 with start held: the original divide must not
        // complete; the re-accepted one cannot finish inside the window.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        annul_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (ready_o) seen++;
        end
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (ready_o) seen++;
        end
        $display("annul mid-ON: ready_o high on %0d sampled edges", seen);
        check("annul.noready", 64'(seen), 64'd0);
        do_div("u9_3",     1'b0, 32'd9,        32'd3,        64'h00000000_00000003, 34, 0);

        // Reset mid-ON, held together with start_i.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        $display("reset mid-ON: ready_o=%0d result_o=%h", ready_o, result_o);
        check("rst_on.rdy", {63'd0, ready_o}, 64'd0);
        check("rst_on.res", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;
        do_div("smin_-1",  1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 34, 0);

        // Reset while END is presenting a result.
        @(negedge clk);
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (ready_o) break;
        end
        check("rst_end.pre", {63'd0, ready_o}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        $display("reset in END: ready_o=%0d result_o=%h", ready_o, result_o);
        check("rst_end.rdy", {63'd0, ready_o}, 64'd0);
        check("rst_end.res", result_o, 64'd0);
        @(negedge clk);
        rst = 1'b0; start_i = 1'b0;
        @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div.md
DIV -- requirements
Module: div

Interface
REQ-001 The block SHALL have one clock and one reset; reset is synchronous and active-high, named as in the codebase: clk, rst.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 signed_div_i  input  1  1 = signed division (DIV), 0 = unsigned (DIVU); sampled with start_i.
REQ-005 opdata1_i  input  32  dividend; sampled with start_i.
REQ-006 opdata2_i  input  32  divisor; sampled with start_i.
REQ-007 start_i  input  1  EX-stage request; held high until ready_o has been seen.
REQ-008 annul_i  input  1  cancel request, e.g. on an exception flush.
REQ-009 result_o  output  64  {remainder[63:32], quotient[31:0]}, written as {HI, LO}.
REQ-010 ready_o  output  1  result valid; EX drops its stall request on this.

Function
REQ-011 The FSM SHALL have four states: FREE, BYZERO, ON, END.
REQ-012 FREE, start_i=1 and annul_i=0, opdata2_i=0: SHALL go to BYZERO.
REQ-013 FREE, start_i=1 and annul_i=0, opdata2_i!=0: SHALL latch |opdata1_i|, |opdata2_i|, signed_div_i and both operand signs, clear cnt, and go to ON.
REQ-014 In unsigned mode, or for non-negative operands, absolute value SHALL be the raw value; negative signed operands SHALL use two's complement (~x+1).
REQ-015 FREE, start_i=0 or annul_i=1: SHALL stay in FREE with ready_o=0 and result_o=0.
REQ-016 ON SHALL perform one restoring radix-2 step per cycle on a 65-bit working register for cnt=0..31 (32 cycles):
- 33-bit trial subtract of the divisor from the upper partial remainder;
- shift in quotient bit 1 on non-negative difference, else 0.
REQ-017 ON, cnt=32: SHALL sign-correct and go to END.
- Quotient negated iff signed mode and operand signs differ.
- Remainder negated iff signed mode and dividend negative.
REQ-018 ON, annul_i=1: SHALL go to FREE the next edge, discard work, keep ready_o=0.
REQ-019 BYZERO: SHALL set result 0 and go to END.
REQ-020 END: SHALL drive ready_o=1 and result_o={rem,quot} (registered) while start_i=1.
REQ-021 END, start_i=0: SHALL go to FREE with ready_o=0 and result_o=0 the next edge.
REQ-022 Operand changes after acceptance SHALL NOT affect the result.
REQ-023 annul_i SHALL be ignored in BYZERO and END.
REQ-024 Latency from the accepting edge E0 SHALL be fixed:
- normal: ready_o high after edge E34;
- divide-by-zero: after E2.
REQ-025 0x80000000 / 0xFFFFFFFF signed SHALL give quotient 0x80000000, remainder 0, with no trap.

Reset
REQ-026 rst=1 at a clock edge SHALL force FREE, cnt=0, working register=0, ready_o=0, result_o=0 regardless of state (including mid-ON).
REQ-027 rst SHALL take priority over start_i and annul_i.

Configuration
REQ-028 Macro DIV_EARLY_TERM_EN controls early termination.
- Defined: in FREE, a nonzero divisor with |dividend| < |divisor| goes directly to END, result quotient 0, remainder = opdata1_i (original signed value); ready_o high after E1.
- Undefined: all nonzero-divisor cases take the full 34-cycle path with identical results.

Verification
REQ-029 Unsigned 100/7, start held -> ready_o after 34 edges, result_o=0x00000002_0000000E.
REQ-030 Signed -7/2 (0xFFFFFFF9, 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD.
REQ-031 opdata2_i=0, start -> ready_o after 2 edges, result_o=0; start_i low -> ready_o=0 next edge.
REQ-032 annul_i pulsed 10 cycles after start -> FREE next edge, ready_o never asserts; new 9/3 start then yields 0x00000000_00000003.
REQ-033 rst asserted mid-ON -> all outputs 0 next edge; signed 0x80000000/0xFFFFFFFF afterwards -> 0x00000000_80000000.
REQ-034 DIV_EARLY_TERM_EN defined, unsigned 5/9 -> ready_o after 1 edge, result_o=0x00000005_00000000; undefined -> same value after 34 edges.
